// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// Frame = {cmd[1:0], payload}; the mode bit preceding it selects the receive state.
package spi_pkg;

  localparam int FRAME_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load / serial-out MISO shifter, MSB first; MISO is the register MSB.
// One bit per enabled cycle after load; zeros shift in so MISO rests at 0; no backpressure.
module spi_tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         dout,
  output logic         done
);

  logic [W-1:0] sr_q, sr_d;
  logic [3:0]   cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (load) begin
      sr_d  = din;
      cnt_d = 4'(W);
    end else if (shift_en && (cnt_q != 4'd0)) begin
      sr_d  = {sr_q[W-2:0], 1'b0};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = sr_q[W-1];
  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: mode bit + 10-bit frame deserialiser with a one-cycle rx_valid, and a
// read-data responder that serialises the RAM byte on MISO; SS_n high aborts any frame.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = FRAME_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int         FW        = ADDR_SIZE + 2;
  localparam logic [3:0] FRAME_LEN = 4'(FW);
  localparam logic [3:0] LAST_BIT  = 4'(FW - 1);

  spi_state_e      state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [FW-2:0]   shift_q, shift_d;
  logic [FW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_addr_seen_q, rd_addr_seen_d;
  logic            tx_wait_q, tx_wait_d;

  logic            tx_clr, tx_load, tx_shift, tx_done;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_wait_d      = tx_wait_q;
    tx_clr         = 1'b0;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (!MOSI)               state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        // Once the counter reaches FRAME_LEN the rest of the frame is ignored.
        if (bit_cnt_q < FRAME_LEN) begin
          shift_d   = {shift_q[FW-3:0], MOSI};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
          end
        end
        // The wait for tx_valid opens only after our own rx_valid, so a level
        // still held from an older read cannot be mistaken for the answer.
        if (state_q == READ_DATA) begin
          if (rx_valid_q) begin
            tx_wait_d = 1'b1;
          end else if (tx_wait_q && tx_valid) begin
            tx_load   = 1'b1;
            tx_wait_d = 1'b0;
          end
          tx_shift = !tx_done;
        end
      end
      default: state_d = IDLE;
    endcase

    if (SS_n && (state_q != IDLE)) begin
      state_d        = IDLE;
      bit_cnt_d      = '0;
      shift_d        = '0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      tx_wait_d      = 1'b0;
      tx_clr         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_wait_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_wait_q      <= tx_wait_d;
    end
  end

  spi_tx_shifter #(.W(ADDR_SIZE)) u_tx_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (tx_clr),
    .load     (tx_load),
    .shift_en (tx_shift),
    .din      (tx_data),
    .dout     (MISO),
    .done     (tx_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frame table, reset corner cases, then random frames vs a model.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  // Cycle numbers: cycle 0 is the cycle SS_n is first sampled low.
  // abort_at: cycle SS_n goes high early (-1: full frame); tx_cyc: first cycle tx_valid is offered in the wait phase.
  typedef struct {
    logic       mode;
    logic [9:0] payload;
    int         abort_at;
    int         tx_cyc;
    logic [7:0] tx_byte;
    int         exp_vld_cyc;
    logic [9:0] exp_rx;
    int         exp_miso_cyc;
    logic [7:0] exp_byte;
    logic       exp_seen;
  } vec_t;

  logic       obs_vld  [0:63];
  logic       obs_miso [0:63];
  logic       obs_idle [0:63];
  logic [9:0] obs_rx   [0:63];

  logic       m_seen;
  logic [9:0] m_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ss, input logic mosi, input logic txv,
                       input logic [7:0] txd, input logic r);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input vec_t v);
    if (v.abort_at >= 0) return v.abort_at;
    if (v.tx_cyc >= 0)   return v.tx_cyc + 10;
    return 14;
  endfunction

  task automatic run_frame(input vec_t v);
    int L;
    L = frame_len(v);
    for (int c = 0; c <= L + 1; c++) begin
      logic ss, mosi, txv;
      ss = (c >= L);
      if (c == 1)                mosi = v.mode;
      else if (c >= 2 && c <= 11) mosi = v.payload[11 - c];
      else                       mosi = 1'($urandom);
      if (v.tx_cyc >= 0 && c >= 13) txv = (c >= v.tx_cyc);
      else                          txv = 1'($urandom);
      drive(ss, mosi, txv, txv ? v.tx_byte : 8'($urandom), 1'b0);
      obs_vld[c+1]  = rx_valid;
      obs_miso[c+1] = MISO;
      obs_rx[c+1]   = rx_data;
      obs_idle[c+1] = (dut.state_q == IDLE);
    end
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    int   L;
    logic em;
    L = frame_len(v);
    for (int c = 1; c <= L + 2; c++) begin
      check($sformatf("%s rx_valid c%0d", tag, c), obs_vld[c], c == v.exp_vld_cyc);
      em = 1'b0;
      if (v.exp_miso_cyc >= 0 && c >= v.exp_miso_cyc && c < v.exp_miso_cyc + 8)
        em = v.exp_byte[7 - (c - v.exp_miso_cyc)];
      check($sformatf("%s miso c%0d", tag, c), obs_miso[c], em);
    end
    if (v.exp_vld_cyc >= 0)
      check($sformatf("%s rx_data@vld", tag), obs_rx[v.exp_vld_cyc], v.exp_rx);
    check($sformatf("%s rx_data end", tag), obs_rx[L+2], v.exp_rx);
    if (v.abort_at >= 0)
      check($sformatf("%s idle after abort", tag), obs_idle[v.abort_at+1], 1'b1);
    check($sformatf("%s rd_addr_seen", tag), dut.rd_addr_seen_q, v.exp_seen);
  endtask

  // Reference: what a frame should do, from the frame rules alone.
  task automatic model(inout vec_t v);
    v.exp_vld_cyc  = -1;
    v.exp_miso_cyc = -1;
    v.exp_byte     = v.tx_byte;
    if (v.abort_at >= 0) begin
      v.exp_rx = m_rx;
    end else begin
      m_rx          = v.payload;
      v.exp_rx      = v.payload;
      v.exp_vld_cyc = 12;
      if (v.mode) begin
        if (m_seen) begin
          v.exp_miso_cyc = v.tx_cyc + 1;
          m_seen = 1'b0;
        end else begin
          m_seen = 1'b1;
        end
      end
    end
    v.exp_seen = m_seen;
  endtask

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;

    tbl[0]  = '{1'b0, 10'h005, -1, -1, 8'h00, 12, 10'h005, -1, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 10'h1A5, -1, -1, 8'h00, 12, 10'h1A5, -1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 10'h205, -1, -1, 8'h00, 12, 10'h205, -1, 8'h00, 1'b1};
    tbl[3]  = '{1'b1, 10'h300, -1, 13, 8'hA5, 12, 10'h300, 14, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 10'h2AA,  7, -1, 8'h00, -1, 10'h300, -1, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 10'h2C3, -1, -1, 8'h00, 12, 10'h2C3, -1, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 10'h3F0, -1, 16, 8'h3C, 12, 10'h3F0, 17, 8'h3C, 1'b0};
    tbl[7]  = '{1'b0, 10'h3FF, -1, -1, 8'h00, 12, 10'h3FF, -1, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 10'h0FF, -1, -1, 8'h00, 12, 10'h0FF, -1, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 10'h155,  4, -1, 8'h00, -1, 10'h0FF, -1, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 10'h012, -1, 13, 8'h81, 12, 10'h012, 14, 8'h81, 1'b0};

    // Reset held while the pins look like an active frame.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_data", rx_data, 10'h000);
    check("reset miso", MISO, 1'b0);
    check("reset state", dut.state_q == IDLE, 1'b1);
    check("reset rd_addr_seen", dut.rd_addr_seen_q, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i]);
      check_frame(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset in the middle of a write frame while a read address is pending.
    v = '{1'b1, 10'h2AA, -1, -1, 8'h00, 12, 10'h2AA, -1, 8'h00, 1'b1};
    run_frame(v);
    check_frame(v, "pre_rst");
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    check("midrst rx_valid", rx_valid, 1'b0);
    check("midrst rx_data", rx_data, 10'h000);
    check("midrst miso", MISO, 1'b0);
    check("midrst state", dut.state_q == IDLE, 1'b1);
    check("midrst rd_addr_seen", dut.rd_addr_seen_q, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    m_seen = 1'b0;
    m_rx   = 10'h000;
    v = '{1'b0, 10'h1B7, -1, -1, 8'h00, 0, 10'h000, 0, 8'h00, 1'b0};
    model(v);
    run_frame(v);
    check_frame(v, "post_rst_wr");
    v = '{1'b1, 10'h241, -1, -1, 8'h00, 0, 10'h000, 0, 8'h00, 1'b0};
    model(v);
    run_frame(v);
    check_frame(v, "post_rst_rd");

    for (int i = 0; i < 40; i++) begin
      v.mode     = 1'($urandom);
      v.payload  = 10'($urandom);
      v.tx_byte  = 8'($urandom);
      v.abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : -1;
      v.tx_cyc   = (v.mode && m_seen && v.abort_at < 0) ? int'($urandom_range(13, 19)) : -1;
      model(v);
      run_frame(v);
      check_frame(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
